dino_run_engine: RTL and testbench
==================================

# dino_run_engine

Game-engine side of the dino game's run/status handshake. Consumes `run_game` from the game-event controller and the jump key. Produces `collision_detected` and `game_cleared` back to that controller. Runs a 16-column obstacle lane, a jump timer and a cleared-obstacle counter, and exports lane and dino state for the LCD/LED renderers.

## Interface
- `TICK_DIV`, default 25_000_000: clk cycles per game step, must be ≥ 2.
- `JUMP_TICKS`, default 3: game steps the dino stays airborne per jump.
- `CLEAR_COUNT`, default 20: obstacles to pass for a clear, range 1–255.
- `LFSR_SEED`, default 16'hACE1: lane generator seed, must be nonzero.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `run_game`  in  1: level from the game-event controller; 1 = game active.
- `key_jump`  in  1: raw keypad jump key, active-high level.
- `collision_detected`  out  1: registered level, 1 while in HIT.
- `game_cleared`  out  1: registered level, 1 while in DONE.
- `lane`  out  16: obstacle map; bit i = column i; column 0 is the left edge.
- `dino_air`  out  1: dino airborne.
- `score`  out  8: obstacles passed in this game.

## Operation
- States are IDLE, PLAY, HIT and DONE.
- Reset state: IDLE. All outputs are 0; lane = 0; jump_cnt = 0; tick counter = 0; LFSR = LFSR_SEED.
- Rising edge of `run_game`, detected from a registered copy, in any state: initialise the game.
  - lane = 0, score = 0, jump_cnt = 0, tick counter = 0, LFSR = LFSR_SEED.
  - Move to PLAY.
- `run_game` low in PLAY freezes the game. The tick counter, lane, LFSR and jump timer all hold.
- HIT and DONE hold every output until the next rising edge of `run_game` or until reset.
- Jump request comes from a rising edge of `key_jump` (one-cycle pulse).
  - It is accepted only in PLAY, with `run_game` high and jump_cnt = 0.
  - On acceptance, jump_cnt = JUMP_TICKS on the next clk.
  - A press while airborne is ignored. It is not queued.
- `dino_air` = (jump_cnt ≠ 0). The dino sits at column DINO_COL = 1.
- Each tick in PLAY is processed in this order, using pre-tick values:
  1. passed = lane[DINO_COL]. An obstacle survived at the dino column last tick and now moves to column 0.
  2. Shift: lane ← {spawn, lane[15:1]}.
  3. Collision if new lane[DINO_COL] = 1 and pre-tick jump_cnt = 0 → HIT.
  4. Otherwise, if passed, score += 1. If the new score = CLEAR_COUNT → DONE.
  5. If jump_cnt > 0, jump_cnt −= 1.
  6. Advance the LFSR one step. Polynomial is x^16+x^14+x^13+x^11+1, Fibonacci form, shifting toward the LSB.
- Spawn rule: spawn = (lfsr[1:0] = 2'b00) and lane[15:15−JUMP_TICKS] all 0. The gap guarantees every obstacle is jumpable.
- If collision and clear qualify on the same tick, collision wins: HIT, and score is not incremented.
- Score saturates at 255.

## Timing
- Tick pulse: asserted for one cycle when the tick counter reaches TICK_DIV−1, after which the counter wraps to 0.
  - The first tick after init comes TICK_DIV cycles after PLAY entry.
- `collision_detected` and `game_cleared` assert on the clk edge that ends the deciding tick cycle. Latency is 1 cycle from the tick pulse.
- Jump latency: `key_jump` rising → 2 clk to `dino_air` = 1 (edge detect register, then the jump_cnt load).
- The game-event controller samples the status flags as levels. They stay stable until `run_game` rises again, so no ack is needed.
- Reset mid-game: immediate return to the reset values, with no tick completion.

## Configuration
- Macro: `DINO_SPEEDUP_EN`.
- Defined:
  - Effective tick period = TICK_DIV >> min(score/8, 2). It halves after every 8 obstacles, down to a floor of TICK_DIV/4.
  - The tick counter compares against the current period.
  - A period change mid-count takes effect when the counter next reaches or exceeds the new period, which resets it to 0.
- Undefined: constant TICK_DIV period. The score-to-speed logic is absent.

## Structure
- Package `dino_pkg` holds:
  - state encoding (IDLE = 2'b00, PLAY = 2'b01, HIT = 2'b10, DONE = 2'b11);
  - LANE_W = 16;
  - DINO_COL = 1;
  - the LFSR tap mask.
- Sub-module `dino_lfsr`: 16-bit LFSR with ports `clk`, `rst`, `load`, `step`, `q`. The `load` input loads LFSR_SEED.
- The jump key edge detect is instantiated inline. No second sub-module.

## Test plan
All scenarios use TICK_DIV = 4, JUMP_TICKS = 3, CLEAR_COUNT = 2 and bench-forced lane preload via hierarchical force unless noted. Unless noted, the scenarios run with `DINO_SPEEDUP_EN` undefined.
- Reset: assert `rst` mid-PLAY → all outputs 0 within the same cycle. After release, state IDLE and no ticks while `run_game` = 0.
- Collision: `run_game` 0→1, lane = 16'h0004, no jump → first tick moves the obstacle to column 1. `collision_detected` = 1 one cycle later and holds with `run_game` at 1 or 0.
- Jump and clear: lane = 16'h0004 and pulse `key_jump` → `dino_air` goes high 2 cycles after the key edge. No collision; the next tick gives score = 1. A second obstacle passed the same way gives `game_cleared` = 1 and score = 2.
- Simultaneous: score = 1, airborne expired, one obstacle at column 1 and one at column 2 → HIT, not DONE, and score stays 1.
- Pause/restart: drop `run_game` for 20 cycles in PLAY → lane and LFSR unchanged. On a new rise after HIT, lane = 0, score = 0, the flags clear within 1 cycle, and the spawn sequence repeats identically from LFSR_SEED.
- `DINO_SPEEDUP_EN`: TICK_DIV = 16 and score forced to 8 → tick spacing becomes 8 cycles. At score ≥ 16 the spacing stays 4 cycles.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared state encoding, lane geometry and LFSR helpers for the dino run engine.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        HIT  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int LANE_W   = 16;
    localparam int DINO_COL = 1;

    // x^16+x^14+x^13+x^11+1, Fibonacci form shifting toward the LSB: taps at bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_advance(input logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/dino_lfsr.sv
// 16-bit lane-generator LFSR; load restores the seed, step advances one position.
module dino_lfsr
    import dino_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= LFSR_SEED;
        else if (load) q <= LFSR_SEED;
        else if (step) q <= lfsr_advance(q);
    end

endmodule

// File: rtl/dino_run_engine.sv
// Dino game engine: obstacle lane, jump timer, score and HIT/DONE status flags.
// Optional DINO_SPEEDUP_EN shortens the tick period as the score grows.
module dino_run_engine
    import dino_pkg::*;
#(
    parameter int          TICK_DIV    = 25_000_000,
    parameter int          JUMP_TICKS  = 3,
    parameter int          CLEAR_COUNT = 20,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_game,
    input  logic              key_jump,
    output logic              collision_detected,
    output logic              game_cleared,
    output logic [LANE_W-1:0] lane,
    output logic              dino_air,
    output logic [7:0]        score
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int JC_W  = $clog2(JUMP_TICKS + 1);
    // Spawning needs the top JUMP_TICKS+1 columns empty so every obstacle is jumpable
    localparam logic [LANE_W-1:0] GAP_MASK = ~({LANE_W{1'b1}} >> (JUMP_TICKS + 1));

    state_t            state, state_next;
    logic              run_q, key_q, jump_pulse;
    logic [CNT_W-1:0]  tick_cnt;
    logic [JC_W-1:0]   jump_cnt;
    logic [15:0]       lfsr;
    logic              run_rise, active, tick;
    logic              passed, spawn, hit, clear_hit, jump_ok;
    logic [LANE_W-1:0] lane_shift;
    logic [7:0]        score_inc;
    logic              unused_lfsr;

    assign run_rise    = run_game & ~run_q;
    assign active      = (state == PLAY) && run_game;
    assign unused_lfsr = ^lfsr[15:2];

`ifdef DINO_SPEEDUP_EN
    logic [1:0]  speed_sh;
    logic [31:0] period_m1;

    // >= rather than == so a period that shrinks mid-count still wraps the counter
    always_comb begin
        speed_sh  = (score >= 8'd16) ? 2'd2 : (score >= 8'd8) ? 2'd1 : 2'd0;
        period_m1 = 32'(TICK_DIV) >> speed_sh;
        period_m1 = (period_m1 == 32'd0) ? 32'd0 : period_m1 - 32'd1;
        tick      = active && (32'(tick_cnt) >= period_m1);
    end
`else
    assign tick = active && (tick_cnt == CNT_W'(TICK_DIV - 1));
`endif

    dino_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (run_rise),
        .step (tick),
        .q    (lfsr)
    );

    always_comb begin
        passed     = lane[DINO_COL];
        spawn      = (lfsr[1:0] == 2'b00) && ((lane & GAP_MASK) == '0);
        lane_shift = {spawn, lane[LANE_W-1:1]};
        hit        = lane_shift[DINO_COL] && (jump_cnt == '0);
        score_inc  = (score == 8'hFF) ? score : score + 8'd1;
        clear_hit  = !hit && passed && (score_inc == 8'(CLEAR_COUNT));
        jump_ok    = jump_pulse && active && (jump_cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Collision outranks clear on the same tick
    always_comb begin
        state_next = state;
        if (run_rise) begin
            state_next = PLAY;
        end else if (tick) begin
            if (hit)            state_next = HIT;
            else if (clear_hit) state_next = DONE;
        end
    end

    always_comb begin
        collision_detected = (state == HIT);
        game_cleared       = (state == DONE);
        dino_air           = (jump_cnt != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= 1'b0;
            key_q      <= 1'b0;
            jump_pulse <= 1'b0;
        end else begin
            run_q      <= run_game;
            key_q      <= key_jump;
            jump_pulse <= key_jump & ~key_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            lane     <= '0;
            score    <= '0;
            jump_cnt <= '0;
        end else if (run_rise) begin
            tick_cnt <= '0;
            lane     <= '0;
            score    <= '0;
            jump_cnt <= '0;
        end else if (active) begin
            if (tick) begin
                tick_cnt <= '0;
                lane     <= lane_shift;
                if (!hit && passed) score <= score_inc;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
            if (jump_ok)                        jump_cnt <= JC_W'(JUMP_TICKS);
            else if (tick && jump_cnt != '0)    jump_cnt <= jump_cnt - JC_W'(1);
        end
    end

endmodule

// File: tb/tb_dino_run_engine.sv
// Scoreboard bench for dino_run_engine: a behavioural game model predicts output snapshots.
`timescale 1ns/1ps
module tb_dino_run_engine;
    import dino_pkg::*;

    localparam int          TD   = 4;
    localparam int          JT   = 3;
    localparam int          CC   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [15:0] lane;
        logic [7:0]  score;
        logic        air;
        logic        coll;
        logic        clr;
    } snap_t;

    logic        clk = 1'b0, rst = 1'b1, run_game = 1'b0, key_jump = 1'b0;
    logic        collision_detected, game_cleared, dino_air;
    logic [15:0] lane;
    logic [7:0]  score;
    snap_t       obs;
    int          total = 0, bad = 0;
    snap_t       exp_q[$];
    string       tag_q[$];
    logic [15:0] pre_lane;

    logic [15:0] m_lane, m_lfsr;
    logic [7:0]  m_score;
    int          m_jc;
    logic        m_hit, m_done;

    assign obs = {lane, score, dino_air, collision_detected, game_cleared};

    dino_run_engine #(.TICK_DIV(TD), .JUMP_TICKS(JT), .CLEAR_COUNT(CC), .LFSR_SEED(SEED)) dut (
        .clk                (clk),
        .rst                (rst),
        .run_game           (run_game),
        .key_jump           (key_jump),
        .collision_detected (collision_detected),
        .game_cleared       (game_cleared),
        .lane               (lane),
        .dino_air           (dino_air),
        .score              (score)
    );

`ifdef DINO_SPEEDUP_EN
    logic        f_run = 1'b0, f_key = 1'b0;
    logic        f_coll, f_clr, f_air;
    logic [15:0] f_lane;
    logic [7:0]  f_score;

    dino_run_engine #(.TICK_DIV(16), .JUMP_TICKS(JT), .CLEAR_COUNT(200), .LFSR_SEED(SEED)) u_fast (
        .clk                (clk),
        .rst                (rst),
        .run_game           (f_run),
        .key_jump           (f_key),
        .collision_detected (f_coll),
        .game_cleared       (f_clr),
        .lane               (f_lane),
        .dino_air           (f_air),
        .score              (f_score)
    );
`endif

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] lfsr_ref(input logic [15:0] q);
        logic fb;
        fb = q[0] ^ q[2] ^ q[3] ^ q[5];
        return {fb, q[15:1]};
    endfunction

    task automatic model_init();
        m_lane = '0; m_lfsr = SEED; m_score = '0; m_jc = 0; m_hit = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_tick();
        logic        p, sp;
        logic [15:0] nl;
        if (m_hit || m_done) return;
        p  = m_lane[1];
        sp = (m_lfsr[1:0] == 2'b00) && (m_lane[15:12] == 4'h0);
        nl = {sp, m_lane[15:1]};
        if (nl[1] && m_jc == 0) m_hit = 1'b1;
        else if (p) begin
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
            if (m_score == 8'(CC)) m_done = 1'b1;
        end
        m_lane = nl;
        if (m_jc > 0) m_jc = m_jc - 1;
        m_lfsr = lfsr_ref(m_lfsr);
    endtask

    task automatic push(input string tag);
        snap_t s;
        s = {m_lane, m_score, (m_jc != 0), m_hit, m_done};
        exp_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    // Starts a game and preloads the lane right after the init edge
    task automatic init_game(input logic [15:0] preload);
        run_game = 1'b0; cyc(1);
        run_game = 1'b1; cyc(1);
        model_init();
        pre_lane = preload;
        force dut.lane = pre_lane; #1; release dut.lane;
        m_lane = preload;
    endtask

    task automatic test_reset();
        snap_t e; string t;
        rst = 1'b1; run_game = 1'b0; key_jump = 1'b0; cyc(2);
        rst = 1'b0; cyc(1);
        model_init(); push("reset_outputs");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        total++;
        if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d required %0d", dut.state, IDLE); end
        cyc(12); push("idle_no_tick");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        total++;
        if (dut.u_lfsr.q !== SEED) begin bad++; $display("FAIL idle_lfsr: got %h required %h", dut.u_lfsr.q, SEED); end
        init_game(16'h0100);
        cyc(4); model_tick(); push("pre_reset_tick");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        #2 rst = 1'b1; #1;
        model_init(); push("async_reset");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        run_game = 1'b0; cyc(2); rst = 1'b0; cyc(1);
    endtask

    task automatic test_collision();
        snap_t e; string t;
        init_game(16'h0004);
        cyc(3); push("coll_pre_tick");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        cyc(1); model_tick(); push("coll_tick");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        cyc(6); push("coll_hold_run1");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        run_game = 1'b0; cyc(6); push("coll_hold_run0");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
    endtask

    task automatic test_jump_clear();
        snap_t e; string t;
        init_game(16'h0004);
        key_jump = 1'b1; cyc(1); push("jump_lat1");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        cyc(1); m_jc = JT; push("jump_lat2");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        key_jump = 1'b0;
        cyc(2); model_tick(); push("jump_over");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        key_jump = 1'b1; cyc(2); key_jump = 1'b0;
        cyc(2); model_tick(); push("jump_pass1");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        cyc(4); model_tick(); push("jump_land_no_requeue");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        pre_lane = m_lane | 16'h0004;
        force dut.lane = pre_lane; #1; release dut.lane;
        m_lane = pre_lane;
        key_jump = 1'b1; cyc(2); m_jc = JT; key_jump = 1'b0;
        cyc(2); model_tick(); push("jump2_over");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        cyc(4); model_tick(); push("clear");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        cyc(5); push("clear_hold");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
    endtask

    task automatic test_simultaneous();
        snap_t e; string t;
        init_game(16'h0006);
        force dut.score = 8'd1; #1; release dut.score;
        m_score = 8'd1;
        cyc(4); model_tick(); push("simul_hit_wins");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
    endtask

    task automatic test_restart();
        snap_t e; string t;
        run_game = 1'b0; cyc(1);
        run_game = 1'b1; cyc(1);
        model_init(); push("restart_clear");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        for (int i = 0; i < 12; i++) begin
            cyc(4); model_tick(); push($sformatf("restart_tick%0d", i));
            e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        end
        run_game = 1'b0; cyc(20); push("pause_hold");
        e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL %s: got %h required %h", t, obs, e); end
        total++;
        if (dut.u_lfsr.q !== m_lfsr) begin bad++; $display("FAIL pause_lfsr: got %h required %h", dut.u_lfsr.q, m_lfsr); end
    endtask

`ifdef DINO_SPEEDUP_EN
    task automatic test_speedup();
        int gap; logic [15:0] prev; int gap_q[$]; int eg;
        f_run = 1'b1; cyc(1);
        force u_fast.lane = 16'h4000; force u_fast.score = 8'd8; #1;
        release u_fast.lane; release u_fast.score;
        gap_q.push_back(8); gap_q.push_back(8);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                force u_fast.score = 8'd16; #1; release u_fast.score;
                gap_q.push_back(4); gap_q.push_back(4);
            end
            gap = 0; prev = f_lane;
            while (f_lane === prev && gap < 64) begin cyc(1); gap++; end
            eg = gap_q.pop_front(); total++;
            if (gap != eg) begin bad++; $display("FAIL speed_gap%0d: got %0d required %0d", k, gap, eg); end
        end
        f_run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_collision();
        test_jump_clear();
        test_simultaneous();
        test_restart();
`ifdef DINO_SPEEDUP_EN
        test_speedup();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
